// File: rtl/jk_pkg.sv
// Shared definitions for the JK flip-flop monitor family.
// Holds the FSM encoding and the default widths and timeout.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    TRACK = 2'd2,
    FAULT = 2'd3
  } jk_state_e;

  localparam int CNT_W_DEF   = 8;
  localparam int TIMEOUT_DEF = 16;
  localparam int TO_W_DEF    = 5;

endpackage

// File: rtl/jk_edge_detect.sv
// Tracks the previous q sample and emits registered rise/fall pulses.
// One cycle from q_in sample to rise/fall; no backpressure, samples every enabled cycle.
module jk_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic capture,
  input  logic track,
  input  logic q_in,
  output logic q_edge,
  output logic rise,
  output logic fall
);

  logic q_prev;

  // Only a tracking cycle may report an edge; the capture cycle just primes q_prev.
  assign q_edge = track & (q_in ^ q_prev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_prev <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      if (capture | track) q_prev <= q_in;
      rise <= q_edge & q_in;
      fall <= q_edge & ~q_in;
    end
  end

endmodule

// File: rtl/jk_ff_monitor.sv
// Watches q/qbar of a JK flip-flop: edge pulses, saturating toggle count, complement check, stuck watchdog.
// All outputs registered, one cycle after the q_in sample; no backpressure.
module jk_ff_monitor
  import jk_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = TO_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             q_in,
  input  logic             qbar_in,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             cnt_ovf,
  output logic             mismatch,
  output logic             fault,
  output logic             stuck,
  output logic [1:0]       state
);

  localparam logic [TO_W-1:0]  TO_VAL  = TO_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  jk_state_e       state_q, state_n;
  logic [TO_W-1:0] wd_cnt, wd_inc;
  logic [1:0]      mm_cnt, mm_cnt_n;
  logic            in_arm, in_track, sample, mm_now, fault_hit, q_edge;

  assign in_arm   = en && (state_q == ARM);
  assign in_track = en && (state_q == TRACK);
  assign sample   = in_arm || in_track;
  assign mm_now   = (q_in == qbar_in);
  assign state    = state_q;

  jk_edge_detect u_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .capture (in_arm),
    .track   (in_track),
    .q_in    (q_in),
    .q_edge  (q_edge),
    .rise    (rise),
    .fall    (fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n   = state_q;
    mm_cnt_n  = 2'd0;
    fault_hit = 1'b0;
    wd_inc    = (wd_cnt == TO_VAL) ? wd_cnt : wd_cnt + 1'b1;
    // A mismatch streak breaks whenever sampling stops, so only live samples extend it.
    if (sample && mm_now && !clr) mm_cnt_n = (mm_cnt == 2'd2) ? 2'd2 : mm_cnt + 2'd1;
    fault_hit = (mm_cnt_n == 2'd2);
    if (!en) begin
      state_n = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_n = ARM;
        ARM:     state_n = fault_hit ? FAULT : TRACK;
        TRACK:   if (fault_hit) state_n = FAULT;
        FAULT:   if (clr) state_n = ARM;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle_cnt <= '0;
      cnt_ovf    <= 1'b0;
      mismatch   <= 1'b0;
      fault      <= 1'b0;
      stuck      <= 1'b0;
      wd_cnt     <= '0;
      mm_cnt     <= 2'd0;
    end else begin
      mismatch <= sample && mm_now;
      mm_cnt   <= mm_cnt_n;
      if (clr) begin
        toggle_cnt <= '0;
        cnt_ovf    <= 1'b0;
        fault      <= 1'b0;
        stuck      <= 1'b0;
        wd_cnt     <= '0;
      end else begin
        if (fault_hit) fault <= 1'b1;
        if (q_edge) begin
          if (toggle_cnt == CNT_MAX) cnt_ovf <= 1'b1;
          else                       toggle_cnt <= toggle_cnt + 1'b1;
        end
        if (in_track) begin
          wd_cnt <= q_edge ? '0 : wd_inc;
          stuck  <= !q_edge && (wd_inc == TO_VAL);
        end
      end
    end
  end

endmodule

// File: tb/tb_jk_ff_monitor.sv
// Directed bench for jk_ff_monitor; a second instance with CNT_W=3 covers counter saturation.
module tb_jk_ff_monitor;

  logic clk = 1'b0;
  logic rst_n, en, clr, q_in, qbar_in;
  logic       rise, fall, cnt_ovf, mismatch, fault, stuck;
  logic [7:0] toggle_cnt;
  logic [1:0] state;
  logic       d3_rise, d3_fall, d3_ovf, d3_mismatch, d3_fault, d3_stuck;
  logic [2:0] d3_cnt;
  logic [1:0] d3_state;
  logic       q_cur;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jk_ff_monitor dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .q_in(q_in), .qbar_in(qbar_in),
    .rise(rise), .fall(fall), .toggle_cnt(toggle_cnt), .cnt_ovf(cnt_ovf),
    .mismatch(mismatch), .fault(fault), .stuck(stuck), .state(state)
  );

  jk_ff_monitor #(.CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .q_in(q_in), .qbar_in(qbar_in),
    .rise(d3_rise), .fall(d3_fall), .toggle_cnt(d3_cnt), .cnt_ovf(d3_ovf),
    .mismatch(d3_mismatch), .fault(d3_fault), .stuck(d3_stuck), .state(d3_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_q(input logic v);
    q_cur   = v;
    q_in    = v;
    qbar_in = ~v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; drive_q(1'b0);
    #12;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++; if ({rise, fall, cnt_ovf, mismatch, fault, stuck} !== 6'b0) begin bad++; $display("FAIL reset_flags got=%b want=000000", {rise, fall, cnt_ovf, mismatch, fault, stuck}); end
    total++; if (toggle_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", toggle_cnt); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_static();
    en = 1'b1; drive_q(1'b1);
    tick();
    total++; if (state !== 2'd1) begin bad++; $display("FAIL static_arm got=%0d want=1", state); end
    tick();
    total++; if (state !== 2'd2) begin bad++; $display("FAIL static_track got=%0d want=2", state); end
    for (int i = 1; i <= 16; i++) begin
      tick();
      total++; if (stuck !== (i == 16)) begin bad++; $display("FAIL static_stuck cyc=%0d got=%b want=%b", i, stuck, (i == 16)); end
      total++; if ({rise, fall} !== 2'b00) begin bad++; $display("FAIL static_edge cyc=%0d got=%b want=00", i, {rise, fall}); end
    end
    tick();
    total++; if (stuck !== 1'b1) begin bad++; $display("FAIL static_stuck_hold got=%b want=1", stuck); end
    total++; if (toggle_cnt !== 8'd0) begin bad++; $display("FAIL static_cnt got=%0d want=0", toggle_cnt); end
  endtask

  task automatic test_toggle();
    for (int i = 1; i <= 10; i++) begin
      drive_q(~q_cur);
      tick();
      total++; if ({rise, fall} !== {q_cur, ~q_cur}) begin bad++; $display("FAIL toggle_edge cyc=%0d got=%b want=%b", i, {rise, fall}, {q_cur, ~q_cur}); end
      total++; if ({stuck, mismatch} !== 2'b00) begin bad++; $display("FAIL toggle_flags cyc=%0d got=%b want=00", i, {stuck, mismatch}); end
    end
    total++; if (toggle_cnt !== 8'd10) begin bad++; $display("FAIL toggle_cnt got=%0d want=10", toggle_cnt); end
  endtask

  task automatic test_saturate();
    clr = 1'b1; tick(); clr = 1'b0;
    total++; if ({d3_cnt, d3_ovf} !== 4'b0000) begin bad++; $display("FAIL sat_clr0 got=%0d/%b want=0/0", d3_cnt, d3_ovf); end
    for (int i = 1; i <= 9; i++) begin
      drive_q(~q_cur);
      tick();
      total++; if (d3_cnt !== 3'((i < 7) ? i : 7)) begin bad++; $display("FAIL sat_cnt edge=%0d got=%0d want=%0d", i, d3_cnt, (i < 7) ? i : 7); end
      total++; if (d3_ovf !== (i >= 8)) begin bad++; $display("FAIL sat_ovf edge=%0d got=%b want=%b", i, d3_ovf, (i >= 8)); end
    end
    clr = 1'b1; tick(); clr = 1'b0;
    total++; if ({d3_cnt, d3_ovf} !== 4'b0000) begin bad++; $display("FAIL sat_clr got=%0d/%b want=0/0", d3_cnt, d3_ovf); end
  endtask

  task automatic test_clr_edge();
    if (q_cur == 1'b0) begin drive_q(1'b1); tick(); end
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 5; i++) begin drive_q(~q_cur); tick(); end
    total++; if (toggle_cnt !== 8'd5) begin bad++; $display("FAIL clredge_pre got=%0d want=5", toggle_cnt); end
    drive_q(1'b1); clr = 1'b1;
    tick();
    clr = 1'b0;
    total++; if (toggle_cnt !== 8'd0) begin bad++; $display("FAIL clredge_cnt got=%0d want=0", toggle_cnt); end
    total++; if (rise !== 1'b1) begin bad++; $display("FAIL clredge_rise got=%b want=1", rise); end
    tick();
    total++; if ({rise, toggle_cnt} !== 9'd0) begin bad++; $display("FAIL clredge_after got=%b/%0d want=0/0", rise, toggle_cnt); end
  endtask

  task automatic test_mismatch();
    qbar_in = 1'b1; tick();
    total++; if ({mismatch, fault, state} !== {1'b1, 1'b0, 2'd2}) begin bad++; $display("FAIL mm_single got=%b want=1010", {mismatch, fault, state}); end
    qbar_in = 1'b0; tick();
    total++; if ({mismatch, fault} !== 2'b00) begin bad++; $display("FAIL mm_clear got=%b want=00", {mismatch, fault}); end
    qbar_in = 1'b1; tick();
    total++; if ({mismatch, fault} !== 2'b10) begin bad++; $display("FAIL mm_first got=%b want=10", {mismatch, fault}); end
    tick();
    total++; if ({fault, state} !== {1'b1, 2'd3}) begin bad++; $display("FAIL mm_fault got=%b want=111", {fault, state}); end
    drive_q(1'b0); tick();
    total++; if ({rise, fall, state} !== {2'b00, 2'd3}) begin bad++; $display("FAIL mm_frozen_edge got=%b want=0011", {rise, fall, state}); end
    total++; if (toggle_cnt !== 8'd0) begin bad++; $display("FAIL mm_frozen_cnt got=%0d want=0", toggle_cnt); end
    clr = 1'b1; tick(); clr = 1'b0;
    total++; if ({fault, state} !== {1'b0, 2'd1}) begin bad++; $display("FAIL mm_recover got=%b want=001", {fault, state}); end
    tick();
    total++; if (state !== 2'd2) begin bad++; $display("FAIL mm_retrack got=%0d want=2", state); end
  endtask

  task automatic test_async_reset();
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 4; i++) begin drive_q(~q_cur); tick(); end
    total++; if (toggle_cnt !== 8'd4) begin bad++; $display("FAIL arst_pre got=%0d want=4", toggle_cnt); end
    rst_n = 1'b0;
    #2;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL arst_state got=%0d want=0", state); end
    total++; if (toggle_cnt !== 8'd0) begin bad++; $display("FAIL arst_cnt got=%0d want=0", toggle_cnt); end
    total++; if ({rise, fall, cnt_ovf, mismatch, fault, stuck} !== 6'b0) begin bad++; $display("FAIL arst_flags got=%b want=000000", {rise, fall, cnt_ovf, mismatch, fault, stuck}); end
    drive_q(1'b1);
    #2 rst_n = 1'b1;
    tick();
    total++; if ({state, rise} !== {2'd1, 1'b0}) begin bad++; $display("FAIL arst_arm got=%b want=010", {state, rise}); end
    tick();
    total++; if ({state, rise} !== {2'd2, 1'b0}) begin bad++; $display("FAIL arst_track got=%b want=100", {state, rise}); end
    tick();
    total++; if ({rise, fall, toggle_cnt} !== 10'd0) begin bad++; $display("FAIL arst_spurious got=%b/%0d want=00/0", {rise, fall}, toggle_cnt); end
  endtask

  task automatic test_disable();
    drive_q(1'b0); tick();
    total++; if ({fall, toggle_cnt} !== {1'b1, 8'd1}) begin bad++; $display("FAIL dis_pre got=%b/%0d want=1/1", fall, toggle_cnt); end
    en = 1'b0; drive_q(1'b1); tick();
    total++; if ({state, rise, fall} !== {2'd0, 2'b00}) begin bad++; $display("FAIL dis_idle got=%b want=0000", {state, rise, fall}); end
    total++; if (toggle_cnt !== 8'd1) begin bad++; $display("FAIL dis_cnt got=%0d want=1", toggle_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_static();
    test_toggle();
    test_saturate();
    test_clr_edge();
    test_mismatch();
    test_async_reset();
    test_disable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
